// File: rtl/mvm_pkg.sv
// Shared defaults, derived widths and the collector state type for the
// mvm_result_collector slice.
package mvm_pkg;

  localparam int K_DEF = 8;
  localparam int B_DEF = 12;
  localparam int IDX_W = $clog2(K_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } coll_state_t;

endpackage

// File: rtl/mvm_sat_relu.sv
// Combinational result conditioning: optional ReLU, then signed saturation of
// a 2*B-bit MVM word down to OUT_W bits with a clip flag.
module mvm_sat_relu #(
  parameter int B     = 12,
  parameter int OUT_W = 16,
  parameter int RELU  = 0
) (
  input  logic [2*B-1:0]   din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);

  localparam int IW = 2 * B;

  logic signed [IW-1:0] r;

  always_comb begin
    r = $signed(din);
    if (RELU != 0 && din[IW-1]) r = '0;
  end

  generate
    if (OUT_W >= IW) begin : g_wide
      // Output is at least as wide as the input: plain sign extension.
      always_comb begin
        dout = OUT_W'(r);
        sat  = 1'b0;
      end
    end else begin : g_narrow
      localparam logic signed [IW-1:0] MAX_V = {{(IW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [IW-1:0] MIN_V = {{(IW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        dout = r[OUT_W-1:0];
        sat  = 1'b0;
        if (r > MAX_V) begin
          dout = MAX_V[OUT_W-1:0];
          sat  = 1'b1;
        end else if (r < MIN_V) begin
          dout = MIN_V[OUT_W-1:0];
          sat  = 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mvm_result_collector.sv
// Captures one K-word MVM result frame after a done rise, conditions each word
// and drains the frame over a valid/ready stream.
module mvm_result_collector
  import mvm_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int B     = B_DEF,
  parameter int OUT_W = 16,
  parameter int RELU  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 done,
  input  logic [2*B-1:0]       data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [$clog2(K)-1:0] out_idx,
  output logic                 out_last,
  output logic                 out_sat,
  output logic                 busy,
  output logic                 overrun,
  output logic [15:0]          frame_count
);

  // Stream handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low every
  // out_* signal holds; out_ready is ignored while out_valid is low.

  localparam int                IW       = $clog2(K);
  localparam logic [IW-1:0]     LAST_IDX = IW'(K - 1);

  coll_state_t      state_q, state_d;
  logic             done_q;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    rd_q, rd_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             rise, cap_en;
  logic [OUT_W-1:0] proc_data;
  logic             proc_sat;
  logic [OUT_W-1:0] buf_q [K];
  logic [K-1:0]     sat_q;

  mvm_sat_relu #(.B(B), .OUT_W(OUT_W), .RELU(RELU)) u_sat_relu (
    .din  (data_in),
    .dout (proc_data),
    .sat  (proc_sat)
  );

  assign rise = done & ~done_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rd_d          = rd_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;
    cap_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = CAPTURE;
          idx_d   = '0;
        end
      end
      CAPTURE: begin
        cap_en = 1'b1;
        if (rise) overrun_d = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          idx_d   = '0;
          rd_d    = '0;
        end
      end
      DRAIN: begin
        // A rise here, including on the final transfer edge, never starts a capture.
        if (rise) overrun_d = 1'b1;
        if (out_ready) begin
          rd_d = rd_q + 1'b1;
          if (rd_q == LAST_IDX) begin
            state_d       = IDLE;
            rd_d          = '0;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      idx_q         <= '0;
      rd_q          <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done;
      idx_q         <= idx_d;
      rd_q          <= rd_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Frame storage needs no reset: it is only observed in DRAIN, after a full capture.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      buf_q[idx_q] <= proc_data;
      sat_q[idx_q] <= proc_sat;
    end
  end

  always_comb begin
    out_valid = (state_q == DRAIN);
    out_data  = out_valid ? buf_q[rd_q] : '0;
    out_idx   = out_valid ? rd_q : '0;
    out_sat   = out_valid ? sat_q[rd_q] : 1'b0;
    out_last  = out_valid && (rd_q == LAST_IDX);
  end

  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule
